uart_tx_fifo: RTL and testbench

// - Buffered UART transmitter: accepts bytes over a valid/ready handshake, queues them in a FIFO,

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_fifo_mem.sv | 63 ++++++
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// FSM state encodings, frame constants and the baud divisor helper.
// Even parity is enabled in the transmitter by defining UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    // Clocks per bit; integer division truncates toward the faster baud
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Byte FIFO for the UART transmitter: synchronous write, asynchronous read
// of the head entry, with level/full/empty flags. Push is ignored when full,
// pop is ignored when empty, and a simultaneous push/pop keeps the level.
module uart_tx_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [7:0]        i_wdata,
    input  logic              i_pop,
    output logic [7:0]        o_rdata,
    output logic [ADDR_W:0]   o_level,
    output logic              o_full,
    output logic              o_empty
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_level == FULL_LEVEL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; level tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter. Bytes enter a FIFO over a valid/ready handshake
// and are serialised LSB first as back-to-back 8N1 frames on a registered txd.
// Defining UART_TX_PARITY_EN inserts an even-parity bit after D7 (8E1 frames).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | line idle high, waiting for the FIFO to become non-empty
// ST_START  | start bit (low) for one bit period
// ST_DATA   | eight data bits, LSB first, shift register drives the line
// ST_PARITY | even parity of the byte (only with UART_TX_PARITY_EN)
// ST_STOP   | stop bit (high); pops the next byte straight into ST_START
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int CLK_FREQ   = 50_000_000,
    parameter  int BAUD       = 9600,
    parameter  int FIFO_DEPTH = 16,
    localparam int ADDR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    output logic              tx_busy,
    output logic [ADDR_W:0]   fifo_level
);

    localparam int               BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int               CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_txd;
`ifdef UART_TX_PARITY_EN
    logic             r_parity;
`endif

    logic             w_bit_end;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic [7:0]       w_rdata;
    logic [ADDR_W:0]  w_level;

    uart_tx_fifo_mem #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (tx_valid && tx_ready),
        .i_wdata (tx_data),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_bit_end  = (r_cnt == CNT_LAST);
    // Pop from idle, or at the end of a stop bit so frames abut with no gap
    assign w_pop      = !w_empty &&
                        ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));
    assign tx_ready   = !w_full;
    assign tx_busy    = (r_state != ST_IDLE) || (w_level != '0);
    assign fifo_level = w_level;
    assign txd        = r_txd;

    // Frame sequencer, bit timer and registered line driver (txd lags state by one clock)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_cnt <= ((r_state == ST_IDLE) || w_bit_end) ? '0 : r_cnt + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_txd <= IDLE_LEVEL;
                    if (w_pop) begin
                        r_shift  <= w_rdata;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_rdata;
`endif
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    r_txd <= 1'b0;
                    if (w_bit_end) begin
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    r_txd <= r_shift[0];
                    if (w_bit_end) begin
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    r_txd <= r_parity;
                    if (w_bit_end) begin
                        r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    r_txd <= IDLE_LEVEL;
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shift  <= w_rdata;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_rdata;
`endif
                            r_state  <= ST_START;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_txd   <= IDLE_LEVEL;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at BAUD_DIV=10, FIFO_DEPTH=16.
// Define UART_TX_PARITY_EN for both bench and RTL to exercise 8E1 frames.
module tb_uart_tx_fifo;

    localparam int BD = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FR = NBITS * BD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       txd;
    logic       tx_busy;
    logic [4:0] fifo_level;

    int tests = 0;
    int fails = 0;

    logic [7:0] rx_q[$];
    bit         mon_en = 1'b1;

    uart_tx_fifo #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Entered on the first sample with the start bit on the line; checks every clock of the frame
    task automatic check_frame(input logic [7:0] b, input logic busy_end, input string tag);
        for (int j = 0; j < NBITS; j++) begin
            for (int c = 0; c < BD; c++) begin
                chk($sformatf("%s_bit%0d_clk%0d", tag, j, c), txd, frame_bit(b, j));
                if (j == NBITS-1 && c == BD-2) chk({tag, "_busy_stop"}, tx_busy, 1'b1);
                if (j == NBITS-1 && c == BD-1) chk({tag, "_busy_end"}, tx_busy, busy_end);
                tick();
            end
        end
    endtask

    // Single push into an idle block, latency checks, then the whole frame
    task automatic send_one(input logic [7:0] b, input string tag);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk({tag, "_lvl_push"}, fifo_level, 5'd1);
        chk({tag, "_busy_push"}, tx_busy, 1'b1);
        chk({tag, "_txd_push"}, txd, 1'b1);
        tick();
        chk({tag, "_lvl_pop"}, fifo_level, 5'd0);
        chk({tag, "_txd_pop"}, txd, 1'b1);
        tick();
        check_frame(b, 1'b0, tag);
    endtask

    // Line monitor: samples each bit at its centre and collects the bytes
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && txd === 1'b0) begin
                repeat (BD/2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (BD) @(negedge clk);
                    b[k] = txd;
                end
`ifdef UART_TX_PARITY_EN
                repeat (BD) @(negedge clk);
`endif
                repeat (BD) @(negedge clk);
                if (mon_en) rx_q.push_back(b);
            end
        end
    end

    initial begin
        logic [7:0] vals3[20];
        logic [7:0] vals4[17];
        int         acc;
        int         guard;
        int         lowc;
        int         runs[$];
        bit         fell;
        logic       rdy;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) tick();
        chk("rst_txd", txd, 1'b1);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_level", fifo_level, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_txd", txd, 1'b1);

        // Single bytes: 0x4A (three ones) and 0x03 (two ones)
        send_one(8'h4A, "t1_4a");
        send_one(8'h03, "t1_03");

        // Three back-to-back pushes: contiguous frames, level 2,1,0
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        tick();
        chk("t2_lvl_a", fifo_level, 5'd1);
        tx_data = 8'hAA;
        tick();
        chk("t2_lvl_b", fifo_level, 5'd1);
        tx_data = 8'h0F;
        tick();
        tx_valid = 1'b0;
        chk("t2_lvl_c", fifo_level, 5'd2);
        check_frame(8'h55, 1'b1, "t2_55");
        chk("t2_lvl_after1", fifo_level, 5'd1);
        check_frame(8'hAA, 1'b1, "t2_aa");
        chk("t2_lvl_after2", fifo_level, 5'd0);
        check_frame(8'h0F, 1'b0, "t2_0f");

        // Streaming 20 bytes with tx_valid held: backpressure and ordering
        for (int i = 0; i < 20; i++) vals3[i] = 8'(8'hC3 ^ (i * 37));
        rx_q.delete();
        acc      = 0;
        guard    = 0;
        lowc     = 0;
        fell     = 1'b0;
        tx_data  = vals3[0];
        tx_valid = 1'b1;
        while (acc < 20 && guard < 5*FR) begin
            rdy = tx_ready;
            tick();
            guard++;
            if (rdy) begin
                acc++;
                if (acc < 20) tx_data = vals3[acc];
                else tx_valid = 1'b0;
            end
            if (!tx_ready) lowc++;
            else if (lowc > 0) begin
                runs.push_back(lowc);
                lowc = 0;
            end
            if (!fell && !tx_ready) begin
                fell = 1'b1;
                chk("t3_accepts_at_full", acc, 17);
                chk("t3_level_full", fifo_level, 5'd16);
            end
        end
        tx_valid = 1'b0;
        chk("t3_all_accepted", acc, 20);
        chk("t3_run0", (runs.size() > 0) ? runs[0] : -1, FR-15);
        chk("t3_run1", (runs.size() > 1) ? runs[1] : -1, FR-1);
        guard = 0;
        while (rx_q.size() < 20 && guard < 20*FR) begin
            tick();
            guard++;
        end
        chk("t3_rx_count", rx_q.size(), 20);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t3_rx%0d", i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, vals3[i]);
        end
        guard = 0;
        while (tx_busy && guard < 2*FR) begin
            tick();
            guard++;
        end
        chk("t3_idle", tx_busy, 1'b0);

        // FIFO at 15 entries, push on the very edge of the stop-end pop
        for (int i = 0; i < 17; i++) vals4[i] = 8'(8'h5A + i * 11);
        rx_q.delete();
        tx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tx_data = vals4[i];
            tick();
        end
        tx_valid = 1'b0;
        chk("t4_level15", fifo_level, 5'd15);
        repeat (FR-15) tick();
        chk("t4_level_pre", fifo_level, 5'd15);
        chk("t4_txd_stop", txd, 1'b1);
        tx_data  = vals4[16];
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("t4_level_same", fifo_level, 5'd15);
        chk("t4_ready", tx_ready, 1'b1);
        tick();
        chk("t4_next_start", txd, 1'b0);
        guard = 0;
        while (rx_q.size() < 17 && guard < 18*FR) begin
            tick();
            guard++;
        end
        chk("t4_rx_count", rx_q.size(), 17);
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("t4_rx%0d", i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, vals4[i]);
        end
        guard = 0;
        while (tx_busy && guard < 2*FR) begin
            tick();
            guard++;
        end
        chk("t4_idle", tx_busy, 1'b0);

        // Reset in the middle of a 0xFF frame with two bytes still queued
        mon_en   = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick();
        tx_data  = 8'h11;
        tick();
        tx_data  = 8'h22;
        tick();
        tx_valid = 1'b0;
        repeat (30) tick();
        chk("t5_pre_level", fifo_level, 5'd2);
        chk("t5_pre_busy", tx_busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_txd", txd, 1'b1);
        chk("t5_rst_level", fifo_level, 5'd0);
        chk("t5_rst_busy", tx_busy, 1'b0);
        chk("t5_rst_ready", tx_ready, 1'b1);
        tick();
        chk("t5_rst_hold_txd", txd, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3*FR; i++) begin
            tick();
            chk($sformatf("t5_quiet_txd%0d", i), txd, 1'b1);
            chk($sformatf("t5_quiet_busy%0d", i), tx_busy, 1'b0);
        end
        rx_q.delete();
        mon_en = 1'b1;
        send_one(8'h3C, "t5_3c");
        repeat (BD) tick();
        chk("t5_rx_count", rx_q.size(), 1);
        chk("t5_rx_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
